// File: rtl/mem_seq_pkg.sv
// -----------------------------------------------------------------------------
// mem_seq_pkg
// Shared types for the LC-3 SRAM memory sequencer:
//   mem_state_t       : sequencer FSM states
//   op_kind_t         : kind of request accepted from the control unit
//   MMIO_ADDR_DEFAULT : default address of the memory-mapped I/O word
//   decode_op()       : write wins when Mem_WE and Mem_OE are both low
// -----------------------------------------------------------------------------
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACC   = 3'd1,
    RD_DONE  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5,
    WR_DONE  = 3'd6
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_kind_t;

  localparam logic [15:0] MMIO_ADDR_DEFAULT = 16'hFFFF;

  // Mem_WE is active-low; a write request takes priority over a read.
  function automatic op_kind_t decode_op(input logic mem_we_n);
    return mem_we_n ? OP_RD : OP_WR;
  endfunction

endpackage

// File: rtl/sram_mem_sequencer_if.sv
// -----------------------------------------------------------------------------
// sram_mem_sequencer_if
// Control-unit side bus of the memory sequencer.
//   Mem_CE/UB/LB/OE/WE : active-low request strobes from the control unit
//   ADDR               : MAR contents
//   Data_from_CPU      : MDR contents (write data)
//   Data_to_CPU        : registered read data
//   Mem_Ready          : one-cycle completion pulse
// Modports: master = control unit, slave = sequencer.
// -----------------------------------------------------------------------------
interface sram_mem_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [15:0]       ADDR;
  logic [DATA_W-1:0] Data_from_CPU;
  logic [DATA_W-1:0] Data_to_CPU;
  logic              Mem_Ready;

  modport master (
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    input  Data_to_CPU, Mem_Ready
  );

  modport slave (
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    output Data_to_CPU, Mem_Ready
  );
endinterface

// File: rtl/mem_mmio_regs.sv
// -----------------------------------------------------------------------------
// mem_mmio_regs
// Memory-mapped I/O word for the sequencer (present only with MEM_MMIO_EN).
//   Clk, Reset : system clock, synchronous active-high reset
//   addr       : CPU address compared against MMIO_ADDR -> hit
//   wr_en      : write accepted this cycle; loads HEX_out when hit
//   wr_data    : data written to the display register
//   Switches   : board switches, returned as rd_data
//   HEX_out    : display register
// -----------------------------------------------------------------------------
`ifdef MEM_MMIO_EN
module mem_mmio_regs
  import mem_seq_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter logic [15:0] MMIO_ADDR = MMIO_ADDR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] Switches,
  output logic              hit,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] HEX_out
);

  assign hit     = (addr == MMIO_ADDR);
  assign rd_data = Switches;

  always_ff @(posedge Clk) begin
    if (Reset)
      HEX_out <= '0;
    else if (wr_en && hit)
      HEX_out <= wr_data;
  end

endmodule
`endif

// File: rtl/sram_mem_sequencer.sv
// -----------------------------------------------------------------------------
// sram_mem_sequencer
// Turns LC-3 control-unit strobe levels into timed async-SRAM read/write
// cycles and returns read data with a one-cycle Mem_Ready pulse.
//   Clk, Reset    : system clock, synchronous active-high reset
//   bus (slave)   : control-unit request bus, see sram_mem_sequencer_if
//   Switches      : MMIO read source
//   HEX_out       : MMIO display register (0 when MMIO is not built)
//   SRAM_ADDR     : registered SRAM address (CPU address zero-extended)
//   SRAM_*_N      : SRAM strobes, active-low
//   SRAM_DQ_O/T/I : pad write data, pad drive enable (1 = drive), read data
// Build option: define MEM_MMIO_EN to map one word at MMIO_ADDR onto
// Switches (read) / HEX_out (write) instead of SRAM.
// -----------------------------------------------------------------------------
module sram_mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int          ADDR_W    = 20,
  parameter int          DATA_W    = 16,
  parameter int          RD_WAIT   = 2,
  parameter int          WR_WAIT   = 2,
  parameter logic [15:0] MMIO_ADDR = MMIO_ADDR_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  sram_mem_sequencer_if.slave  bus,
  input  logic [DATA_W-1:0]    Switches,
  output logic [DATA_W-1:0]    HEX_out,
  output logic [ADDR_W-1:0]    SRAM_ADDR,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N,
  output logic [DATA_W-1:0]    SRAM_DQ_O,
  output logic                 SRAM_DQ_T,
  input  logic [DATA_W-1:0]    SRAM_DQ_I
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              ub_n_q;
  logic              lb_n_q;

  logic              req;
  logic              rd_keep;
  logic              wr_keep;
  op_kind_t          req_op;
  logic              mmio_hit;
  logic [DATA_W-1:0] mmio_rdata;

  // Request levels: a request exists while CE is low and either strobe is
  // low; an operation stays alive only while its own strobe and CE stay low.
  assign req     = !bus.Mem_CE && (!bus.Mem_WE || !bus.Mem_OE);
  assign rd_keep = !bus.Mem_CE && !bus.Mem_OE;
  assign wr_keep = !bus.Mem_CE && !bus.Mem_WE;
  assign req_op  = decode_op(bus.Mem_WE);

`ifdef MEM_MMIO_EN
  mem_mmio_regs #(
    .DATA_W    (DATA_W),
    .MMIO_ADDR (MMIO_ADDR)
  ) u_mmio (
    .Clk      (Clk),
    .Reset    (Reset),
    .addr     (bus.ADDR),
    .wr_en    ((state == IDLE) && req && (req_op == OP_WR)),
    .wr_data  (bus.Data_from_CPU),
    .Switches (Switches),
    .hit      (mmio_hit),
    .rd_data  (mmio_rdata),
    .HEX_out  (HEX_out)
  );
`else
  // Without MMIO the I/O address is ordinary SRAM.
  logic unused_mmio;
  assign unused_mmio = ^{Switches, MMIO_ADDR};
  assign mmio_hit    = 1'b0;
  assign mmio_rdata  = '0;
  assign HEX_out     = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      cnt             <= '0;
      SRAM_ADDR       <= '0;
      wdata_q         <= '0;
      ub_n_q          <= 1'b1;
      lb_n_q          <= 1'b1;
      bus.Data_to_CPU <= '0;
      bus.Mem_Ready   <= 1'b0;
    end else begin
      bus.Mem_Ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            SRAM_ADDR <= ADDR_W'(bus.ADDR);
            wdata_q   <= bus.Data_from_CPU;
            ub_n_q    <= bus.Mem_UB;
            lb_n_q    <= bus.Mem_LB;
            if (mmio_hit) begin
              // I/O word completes immediately; SRAM is never strobed.
              bus.Mem_Ready <= 1'b1;
              if (req_op == OP_RD) begin
                bus.Data_to_CPU <= mmio_rdata;
                state           <= RD_DONE;
              end else begin
                state <= WR_DONE;
              end
            end else if (req_op == OP_RD) begin
              cnt   <= RD_LOAD;
              state <= RD_ACC;
            end else begin
              state <= WR_SETUP;
            end
          end
        end
        RD_ACC: begin
          if (!rd_keep) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            bus.Data_to_CPU <= SRAM_DQ_I;
            bus.Mem_Ready   <= 1'b1;
            state           <= RD_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_DONE: if (!rd_keep) state <= IDLE;
        WR_SETUP: begin
          if (!wr_keep) begin
            state <= IDLE;
          end else begin
            cnt   <= WR_LOAD;
            state <= WR_PULSE;
          end
        end
        WR_PULSE: begin
          // Once the pulse has started it always runs to full width.
          if (cnt == '0) begin
            bus.Mem_Ready <= 1'b1;
            state         <= WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_HOLD: state <= WR_DONE;
        WR_DONE: if (!wr_keep) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register, so they drop to idle on
  // the same edge that resets or ends an operation. DQ_T and OE_N are owned
  // by disjoint states, and every path between them passes a DQ_T=0 state.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_DQ_T = 1'b0;
    case (state)
      RD_ACC: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        SRAM_CE_N = 1'b0;
        SRAM_DQ_T = 1'b1;
      end
      WR_PULSE: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = 1'b0;
        SRAM_DQ_T = 1'b1;
      end
      default: ;
    endcase
    SRAM_UB_N = SRAM_CE_N | ub_n_q;
    SRAM_LB_N = SRAM_CE_N | lb_n_q;
  end

  assign SRAM_DQ_O = wdata_q;

endmodule

// File: tb/tb_sram_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_sequencer
// Self-checking bench: SRAM pad model, a reference memory updated from the
// request stream, a directed vector table, hand-written corner sequences and
// a randomized request stream.
// -----------------------------------------------------------------------------
module tb_sram_mem_sequencer;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int RD_W   = 2;
  localparam int WR_W   = 2;
  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_BOTH = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sram_mem_sequencer_if #(.DATA_W(DATA_W)) bus ();

  logic [DATA_W-1:0] Switches;
  logic [DATA_W-1:0] HEX_out;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
  logic [DATA_W-1:0] SRAM_DQ_O;
  logic              SRAM_DQ_T;
  logic [DATA_W-1:0] SRAM_DQ_I;

  sram_mem_sequencer #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RD_WAIT (RD_W), .WR_WAIT (WR_W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .Switches  (Switches),
    .HEX_out   (HEX_out),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_DQ_O (SRAM_DQ_O),
    .SRAM_DQ_T (SRAM_DQ_T),
    .SRAM_DQ_I (SRAM_DQ_I)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 263) ^ 16'h5A5A;
  endfunction

  // ---------------- SRAM model (256 words, low address bits) ----------------
  logic [15:0] sram [0:255];
  logic        model_init = 1'b1;
  logic        preload    = 1'b0;
  logic [7:0]  pre_addr   = '0;
  logic [15:0] pre_data   = '0;

  always @(posedge Clk) begin
    if (model_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= pat(i);
    end else if (preload) begin
      sram[pre_addr] <= pre_data;
    end else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_T) begin
      if (!SRAM_UB_N) sram[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ_O[15:8];
      if (!SRAM_LB_N) sram[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ_O[7:0];
    end
  end

  // Undriven read bus returns a marker so a mistimed capture is visible.
  assign SRAM_DQ_I = (!SRAM_CE_N && !SRAM_OE_N && !SRAM_DQ_T) ? sram[SRAM_ADDR[7:0]] : 16'hDEAD;

  // ---------------- pad monitor (cumulative counters) ----------------
  int n_oe = 0, n_we = 0, n_dqt = 0, n_rdy = 0, n_conflict = 0, n_bad_addr = 0, n_bad_be = 0;
  logic [ADDR_W-1:0] exp_sram_addr = '0;
  logic exp_ub_n = 1'b1, exp_lb_n = 1'b1;
  logic prev_oe = 1'b0, prev_dqt = 1'b0;

  always @(negedge Clk) begin
    if (!SRAM_OE_N) n_oe++;
    if (!SRAM_WE_N) n_we++;
    if (SRAM_DQ_T) n_dqt++;
    if (bus.Mem_Ready) n_rdy++;
    if (SRAM_DQ_T && !SRAM_OE_N) n_conflict++;
    if ((SRAM_DQ_T && prev_oe) || (!SRAM_OE_N && prev_dqt)) n_conflict++;
    if (!SRAM_CE_N && SRAM_ADDR !== exp_sram_addr) n_bad_addr++;
    if (!SRAM_CE_N && (SRAM_UB_N !== exp_ub_n || SRAM_LB_N !== exp_lb_n)) n_bad_be++;
    prev_oe  = !SRAM_OE_N;
    prev_dqt = SRAM_DQ_T;
  end

  // ---------------- reference memory ----------------
  logic [15:0] ref_mem [0:255];

  task automatic ref_write(input logic [15:0] addr, input logic [15:0] data, input logic ub_n, input logic lb_n);
    if (!ub_n) ref_mem[addr[7:0]][15:8] = data[15:8];
    if (!lb_n) ref_mem[addr[7:0]][7:0]  = data[7:0];
  endtask

  task automatic bus_idle();
    bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
    bus.Mem_UB = 1'b1; bus.Mem_LB = 1'b1;
  endtask

  // Drive a request at a negedge; accepted on the following posedge.
  task automatic drive(input int kind, input logic [15:0] addr, input logic [15:0] data,
                       input logic ub_n, input logic lb_n);
    exp_sram_addr     = ADDR_W'(addr);
    exp_ub_n          = ub_n;
    exp_lb_n          = lb_n;
    bus.ADDR          = addr;
    bus.Data_from_CPU = data;
    bus.Mem_UB        = ub_n;
    bus.Mem_LB        = lb_n;
    bus.Mem_CE        = 1'b0;
    bus.Mem_OE        = (kind == K_WR) ? 1'b1 : 1'b0;
    bus.Mem_WE        = (kind == K_RD) ? 1'b1 : 1'b0;
  endtask

  // Full operation: latency to Mem_Ready (in cycles after the accept edge),
  // read data, strobe widths, single Mem_Ready, address and byte lanes.
  task automatic run_op(input string tag, input int kind, input logic [15:0] addr,
                        input logic [15:0] data, input logic ub_n, input logic lb_n,
                        input int extra_hold, input bit mmio);
    int b_oe, b_we, b_dqt, b_rdy, b_ad, b_be, lat, exp_lat;
    bit got, is_wr;
    logic [15:0] exp_rd;
    b_oe = n_oe; b_we = n_we; b_dqt = n_dqt; b_rdy = n_rdy; b_ad = n_bad_addr; b_be = n_bad_be;
    is_wr   = (kind != K_RD);
    exp_lat = mmio ? 1 : (is_wr ? 2 + WR_W : RD_W + 1);
    exp_rd  = mmio ? Switches : ref_mem[addr[7:0]];
    got = 1'b0;
    lat = 0;
    drive(kind, addr, data, ub_n, lb_n);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      lat++;
      if (bus.Mem_Ready) got = 1'b1;
    end
    check({tag, " latency"}, got ? lat : 0, exp_lat);
    if (!is_wr) check({tag, " read data"}, bus.Data_to_CPU, exp_rd);
    repeat (extra_hold) @(negedge Clk);
    bus_idle();
    repeat (2) @(negedge Clk);
    check({tag, " OE_N low cycles"}, n_oe - b_oe, (is_wr || mmio) ? 0 : RD_W);
    check({tag, " WE_N low cycles"}, n_we - b_we, (is_wr && !mmio) ? WR_W : 0);
    check({tag, " DQ_T high cycles"}, n_dqt - b_dqt, (is_wr && !mmio) ? WR_W + 2 : 0);
    check({tag, " Mem_Ready pulses"}, n_rdy - b_rdy, 1);
    check({tag, " addr/byte-lane errors"}, (n_bad_addr - b_ad) + (n_bad_be - b_be), 0);
    if (is_wr && !mmio) ref_write(addr, data, ub_n, lb_n);
  endtask

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic        ub_n;
    logic        lb_n;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int b_rdy, b_oe, b_we, b_dqt;
    logic [15:0] saved;
    logic [15:0] r_addr, r_data;
    int r_kind;

    vecs[0] = '{K_RD,   16'h0030, 16'h0000, 1'b0, 1'b0, 16'h1234};
    vecs[1] = '{K_WR,   16'h0040, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{K_RD,   16'h0040, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
    vecs[3] = '{K_BOTH, 16'h0050, 16'h00FF, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{K_RD,   16'h0050, 16'h0000, 1'b0, 1'b0, 16'h00FF};
    vecs[5] = '{K_WR,   16'h0040, 16'h1122, 1'b0, 1'b1, 16'h0000};
    vecs[6] = '{K_RD,   16'h0040, 16'h0000, 1'b0, 1'b0, 16'h11EF};
    vecs[7] = '{K_WR,   16'h0050, 16'hAB34, 1'b1, 1'b0, 16'h0000};
    vecs[8] = '{K_RD,   16'h0050, 16'h0000, 1'b1, 1'b0, 16'h0034};

    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    Switches          = 16'h00A5;
    bus.ADDR          = '0;
    bus.Data_from_CPU = '0;
    bus_idle();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);

    // Reset state.
    check("reset strobes CE/OE/WE/UB/LB", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check("reset DQ_T", SRAM_DQ_T, 1'b0);
    check("reset SRAM_ADDR", SRAM_ADDR, '0);
    check("reset Data_to_CPU", bus.Data_to_CPU, '0);
    check("reset Mem_Ready", bus.Mem_Ready, 1'b0);
    check("reset HEX_out", HEX_out, '0);
    Reset      = 1'b0;
    model_init = 1'b0;

    // SRAM model holds 0x1234 at 0x0030.
    preload  = 1'b1;
    pre_addr = 8'h30;
    pre_data = 16'h1234;
    @(negedge Clk);
    preload = 1'b0;
    ref_mem[8'h30] = 16'h1234;
    @(negedge Clk);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].kind, vecs[i].addr, vecs[i].data,
             vecs[i].ub_n, vecs[i].lb_n, 0, 1'b0);
      if (vecs[i].kind == K_RD)
        check($sformatf("vec%0d table data", i), bus.Data_to_CPU, vecs[i].exp_rd);
    end

    // Read aborted in the first RD_ACC cycle.
    saved = bus.Data_to_CPU;
    b_rdy = n_rdy; b_oe = n_oe;
    drive(K_RD, 16'h0030, 16'h0000, 1'b0, 1'b0);
    @(negedge Clk);
    bus.Mem_OE = 1'b1;
    repeat (4) @(negedge Clk);
    check("rd abort Mem_Ready", n_rdy - b_rdy, 0);
    check("rd abort OE_N cycles", n_oe - b_oe, 1);
    check("rd abort Data_to_CPU", bus.Data_to_CPU, saved);
    bus_idle();
    @(negedge Clk);
    run_op("after rd abort", K_RD, 16'h0030, 16'h0000, 1'b0, 1'b0, 0, 1'b0);

    // Write aborted in WR_SETUP: no WE pulse, memory untouched.
    b_rdy = n_rdy; b_we = n_we; b_dqt = n_dqt;
    drive(K_WR, 16'h0060, 16'h7777, 1'b0, 1'b0);
    @(negedge Clk);
    bus.Mem_WE = 1'b1;
    repeat (4) @(negedge Clk);
    check("wr abort Mem_Ready", n_rdy - b_rdy, 0);
    check("wr abort WE_N cycles", n_we - b_we, 0);
    check("wr abort DQ_T cycles", n_dqt - b_dqt, 1);
    bus_idle();
    @(negedge Clk);
    run_op("after wr abort", K_RD, 16'h0060, 16'h0000, 1'b0, 1'b0, 0, 1'b0);

    // Release during WR_PULSE: the write still completes in full.
    b_rdy = n_rdy; b_we = n_we; b_dqt = n_dqt;
    drive(K_WR, 16'h0070, 16'hC3C3, 1'b0, 1'b0);
    repeat (2) @(negedge Clk);
    bus_idle();
    repeat (6) @(negedge Clk);
    check("wr release Mem_Ready", n_rdy - b_rdy, 1);
    check("wr release WE_N cycles", n_we - b_we, WR_W);
    check("wr release DQ_T cycles", n_dqt - b_dqt, WR_W + 2);
    ref_write(16'h0070, 16'hC3C3, 1'b0, 1'b0);
    run_op("wr release readback", K_RD, 16'h0070, 16'h0000, 1'b0, 1'b0, 0, 1'b0);

    // Reset during WR_PULSE.
    b_rdy = n_rdy;
    drive(K_WR, 16'h0080, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(negedge Clk);
    check("pre-reset WE_N low", SRAM_WE_N, 1'b0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("reset edge WE_N/OE_N/CE_N", {SRAM_WE_N, SRAM_OE_N, SRAM_CE_N}, 3'b111);
    check("reset edge DQ_T", SRAM_DQ_T, 1'b0);
    check("reset edge SRAM_ADDR", SRAM_ADDR, '0);
    check("reset edge Data_to_CPU", bus.Data_to_CPU, '0);
    check("reset edge Mem_Ready", bus.Mem_Ready, 1'b0);
    @(negedge Clk);
    bus_idle();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    check("reset write Mem_Ready", n_rdy - b_rdy, 0);

`ifdef MEM_MMIO_EN
    run_op("mmio read", K_RD, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
    run_op("mmio write", K_WR, 16'hFFFF, 16'h0042, 1'b1, 1'b1, 0, 1'b1);
    check("mmio HEX_out", HEX_out, 16'h0042);
`else
    run_op("ffff sram write", K_WR, 16'hFFFF, 16'h0042, 1'b0, 1'b0, 0, 1'b0);
    run_op("ffff sram read", K_RD, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    check("HEX_out tied", HEX_out, '0);
`endif

    // Randomized request stream against the reference memory.
    for (int i = 0; i < 40; i++) begin
      r_kind = int'($urandom_range(0, 2));
      r_addr = 16'($urandom_range(0, 127));
      r_data = 16'($urandom);
      run_op($sformatf("rand%0d", i), r_kind, r_addr, r_data,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'b0);
    end

    check("DQ_T/OE_N separation violations", n_conflict, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
